// File: rtl/seq_divider.sv
// Radix-2 restoring 32-bit divider for the MIPS HI/LO path (DIV/DIVU), one quotient bit per clock.
// Optional macro SEQ_DIVIDER_ZERO_EARLY_EN: a zero divisor bypasses the iterations and completes early.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             sgn_q, sd_q, sv_q, zero_q;
`ifdef SEQ_DIVIDER_ZERO_EARLY_EN
  logic             early_q;
`endif

  logic [WIDTH:0]   shift_w, diff_w;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic             dvd_neg, dvs_neg;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];

  // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
  always_comb begin
    shift_w = {rem_q, quo_q[WIDTH-1]};
    diff_w  = shift_w - {1'b0, dvs_q};
    quo_d   = {quo_q[WIDTH-2:0], ~diff_w[WIDTH]};
    rem_d   = diff_w[WIDTH] ? shift_w[WIDTH-1:0] : diff_w[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_EARLY_EN
      early_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            sgn_q  <= is_signed;
            sd_q   <= dvd_neg;
            sv_q   <= dvs_neg;
            zero_q <= (divisor == '0);
            dvs_q  <= cond_neg(divisor, dvs_neg);
            quo_q  <= cond_neg(dividend, dvd_neg);
            rem_q  <= '0;
            cnt_q  <= '0;
`ifdef SEQ_DIVIDER_ZERO_EARLY_EN
            if (divisor == '0) begin
              // Natural restoring outcome for a zero divisor: all-ones quotient, remainder = |dividend|.
              quo_q   <= '1;
              rem_q   <= cond_neg(dividend, dvd_neg);
              early_q <= 1'b1;
              state_q <= FIN;
            end else begin
              busy    <= 1'b1;
              state_q <= CALC;
            end
`else
            busy    <= 1'b1;
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            // Sign fix is applied to the final step's result so done lands in the FIN cycle.
            q        <= cond_neg(quo_d, sgn_q & (sd_q ^ sv_q));
            r        <= cond_neg(rem_d, sgn_q & sd_q);
            div_zero <= zero_q;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= FIN;
          end
        end
        FIN: begin
`ifdef SEQ_DIVIDER_ZERO_EARLY_EN
          if (early_q) begin
            early_q  <= 1'b0;
            q        <= cond_neg(quo_q, sgn_q & (sd_q ^ sv_q));
            r        <= cond_neg(rem_q, sgn_q & sd_q);
            div_zero <= zero_q;
            done     <= 1'b1;
          end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            state_q  <= IDLE;
          end
`else
          done     <= 1'b0;
          div_zero <= 1'b0;
          state_q  <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes reference results, a monitor checks each done pulse.
module tb_seq_divider;

  localparam int W = 32;
`ifdef SEQ_DIVIDER_ZERO_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] q, r;
  logic         busy, done, div_zero;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nbusy = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
    int           busy_cycles;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: DIV/DIVU semantics from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sbv, tq, tr;
    e.dz = (b == 0);
    if (b == 0) begin
      e.q = (s && a[W-1]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      e.r = a;
    end else if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      tq  = sa / sbv;
      tr  = sa % sbv;
      e.q = tq[W-1:0];
      e.r = tr[W-1:0];
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.busy_cycles = (EARLY && e.dz) ? 0 : W;
    e.due = 0;
    return e;
  endfunction

  // Monitor: compare every done pulse against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      nbusy = 0;
    end else begin
      if (busy) nbusy++;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got q=%h r=%h with no pending request", q, r);
        end else begin
          e = sb.pop_front();
          check("quotient", q, e.q);
          check("remainder", r, e.r);
          check("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
          check("latency", cyc, e.due);
          check("busy_cycles", nbusy, e.busy_cycles);
          check("busy_at_done", {31'b0, busy}, 32'd0);
        end
        nbusy = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e = model(a, b, s);
    e.due = cyc + 1 + ((EARLY && e.dz) ? 1 : W);
    sb.push_back(e);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected one", n);
    end
  endtask

  // Full operation; a start pulse in the done cycle must be ignored.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    issue(a, b, s);
    wait_done();
    dividend = $urandom; divisor = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] a, b;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_q", q, '0);
    check("reset_r", r, '0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_div_zero", {31'b0, div_zero}, 32'd0);

    op(32'd100, 32'd7, 1'b0);
    op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    op(32'h1234_5678, 32'h0000_0000, 1'b0);
    op(32'h8765_4321, 32'h0000_0000, 1'b1);
    op(32'h8000_0000, 32'h0000_0003, 1'b0);

    // Second start mid-run and operand changes must not disturb the result.
    issue(32'd50, 32'd5, 1'b0);
    repeat (9) @(negedge clk);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
      @(negedge clk);
    end
    wait_done();
    @(negedge clk);
    @(negedge clk);

    // Reset mid-operation abandons it and clears the results.
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_q", q, '0);
    check("abort_r", r, '0);
    op(32'd9, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        default: b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : (32'hFFFF_FFF0 | $urandom_range(0, 15));
      endcase
      op(a, b, 1'($urandom));
    end

    repeat (5) @(negedge clk);
    check("pending_results", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
